// File: rtl/spi_master_engine.sv
// SPI master engine: runs one full-duplex MSB-first transfer per accepted go_transfer strobe,
// framing it with slave-select setup/hold and an inter-frame gap.
module spi_master_engine #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 4,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_transfer,
    input  logic [DATA_W-1:0] data_write_to_spi,
    output logic [DATA_W-1:0] data_read_from_spi,
    output logic              data_pack_ready,
    output logic              go_ignored,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ss_n
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(DATA_W);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_t;

    state_t            state;
    logic [DivW-1:0]   div_cnt;
    logic [BitW-1:0]   bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    logic tick;
    logic lead_half;
    logic lead_edge;
    logic trail_edge;
    logic last_done;

    // The first leading edge is issued on SETUP exit; later ones end each trailing half.
    always_comb begin
        tick       = (div_cnt == DivLast);
        lead_half  = (spi_sclk != CPOL);
        lead_edge  = tick && ((state == StSetup) ||
                              (state == StShift && !lead_half && bit_cnt != BitLast));
        trail_edge = tick && (state == StShift) && lead_half;
        last_done  = tick && (state == StShift) && !lead_half && (bit_cnt == BitLast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= StIdle;
            div_cnt            <= '0;
            bit_cnt            <= '0;
            tx_sr              <= '0;
            rx_sr              <= '0;
            data_read_from_spi <= '0;
            data_pack_ready    <= 1'b0;
            go_ignored         <= 1'b0;
            spi_sclk           <= CPOL;
            spi_mosi           <= 1'b0;
            spi_ss_n           <= 1'b1;
        end else begin
            go_ignored <= go_transfer && (state != StIdle);
            case (state)
                StIdle: begin
                    if (go_transfer) begin
                        tx_sr           <= data_write_to_spi;
                        rx_sr           <= '0;
                        spi_ss_n        <= 1'b0;
                        data_pack_ready <= 1'b1;
                        spi_mosi        <= CPHA ? 1'b0 : data_write_to_spi[DATA_W-1];
                        div_cnt         <= '0;
                        bit_cnt         <= '0;
                        state           <= StSetup;
                    end
                end
                StSetup, StShift: begin
                    div_cnt <= tick ? '0 : div_cnt + DivW'(1);
                    if (lead_edge) begin
                        spi_sclk <= ~CPOL;
                        state    <= StShift;
                        if (state == StShift) bit_cnt <= bit_cnt + BitW'(1);
                        if (!CPHA) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
                        end else begin
                            spi_mosi <= tx_sr[DATA_W-1];
                            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (trail_edge) begin
                        spi_sclk <= CPOL;
                        if (CPHA) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
                        end else if (bit_cnt != BitLast) begin
                            spi_mosi <= tx_sr[DATA_W-2];
                            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (last_done) state <= StHold;
                end
                StHold: begin
                    div_cnt <= tick ? '0 : div_cnt + DivW'(1);
                    if (tick) begin
                        // Word is published in the same clock as the ready fall.
                        spi_ss_n           <= 1'b1;
                        data_pack_ready    <= 1'b0;
                        data_read_from_spi <= rx_sr;
                        spi_mosi           <= 1'b0;
                        state              <= StGap;
                    end
                end
                StGap: begin
                    div_cnt <= tick ? '0 : div_cnt + DivW'(1);
                    if (tick) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
